// File: rtl/deserializador_rx_pkg.sv
// Shared definitions for the one-wire word link.
// Both the transmitter and this receiver use them, so the framing has a
// single definition: idle-high line, START_BIT, DATA_W bits LSB first,
// then STOP_BIT.
package deserializador_rx_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/deserializador_rx_sincronizador_2ff.sv
// Two-flop synchronizer for one asynchronous bit.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-low; loads RESET_VAL into both flops
//   d     - asynchronous input
//   q     - synchronized output, 2 cycles of latency
module sincronizador_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/deserializador_rx.sv
// Serial-to-parallel receiver for the one-wire word link.
// The receiver samples each bit at mid-bit using a local cycle counter.
// It presents each received word on a valid/ready port.
// Ports:
//   clk        - system clock
//   reset      - synchronous, active-low
//   rx         - asynchronous serial line, idle high
//   rd_ready   - consumer takes data this cycle when data_valid=1
//   data       - received word, stable while data_valid=1
//   data_valid - word available, held until accepted
//   frame_err  - one-cycle pulse when the stop bit is sampled low
//   overrun    - sticky: a completed word was dropped; clears on the next accept
//   busy       - receiver is anywhere but IDLE
module deserializador_rx
  import deserializador_rx_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] data,
  output logic              data_valid,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CYC_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_W + 1);

  localparam logic [CYC_W-1:0] HALF_LAST = CYC_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CYC_W-1:0] FULL_LAST = CYC_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

  rx_state_t         state;
  logic [CYC_W-1:0]  cyc_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              rx_s;

  sincronizador_2ff #(
    .RESET_VAL (IDLE_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      cyc_cnt    <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      // An accept clears valid and overrun. A word that completes in the
      // same cycle overrides the valid clear further down.
      if (data_valid && rd_ready) begin
        data_valid <= 1'b0;
        overrun    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rx_s == START_BIT) begin
            state   <= START;
            cyc_cnt <= '0;
          end
        end

        START: begin
          if (cyc_cnt == HALF_LAST) begin
            cyc_cnt <= '0;
            // A line that is high again at mid start bit was a glitch.
            if (rx_s == START_BIT) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        DATA: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            shift   <= {rx_s, shift[DATA_W-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == DATA_LAST) begin
              state <= STOP;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        STOP: begin
          if (cyc_cnt == FULL_LAST) begin
            cyc_cnt <= '0;
            if (rx_s == STOP_BIT) begin
              state <= IDLE;
              if (!data_valid || rd_ready) begin
                data       <= shift;
                data_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end

        // A break (line held low) must not look like a new start bit.
        WAIT_IDLE: begin
          if (rx_s == IDLE_LEVEL) begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_deserializador_rx.sv
module tb_deserializador_rx;

  // Pin falling edge to data_valid: (32 + 1.5) * 16 + 3 = 539 cycles.
  localparam int LAT = 539;
  localparam int CPB = 16;

  typedef struct {
    int unsigned done;
    logic [31:0] word;
    bit          good;
  } frame_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx;
  logic        rd_ready;
  logic [31:0] data;
  logic        data_valid;
  logic        frame_err;
  logic        overrun;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  bit          armed = 1'b0;
  bit          rand_ready = 1'b0;

  // Behavioural model state.
  bit          exp_valid = 1'b0;
  bit          exp_ferr = 1'b0;
  bit          exp_ovr = 1'b0;
  logic [31:0] exp_data = '0;
  frame_t      pend_q[$];

  // Observation log.
  logic [31:0] acc_q[$];
  int unsigned last_start = 0;
  int unsigned last_rise = 0;
  int          rise_cnt = 0;
  int          ferr_cnt = 0;
  bit          prev_valid = 1'b0;

  always #5 clk = ~clk;

  deserializador_rx #(
    .DATA_W       (32),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rd_ready   (rd_ready),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic busy_cycle(input logic e, input string name);
    @(negedge clk);
    check(name, {31'd0, busy}, {31'd0, e});
    @(posedge clk);
    #1;
  endtask

  // Sends one frame starting now. The caller must be 1 time unit after a posedge.
  task automatic send_frame(input logic [31:0] w, input bit good);
    frame_t f;
    rx         = 1'b0;
    last_start = cyc;
    f.done     = cyc + LAT;
    f.word     = w;
    f.good     = good;
    pend_q.push_back(f);
    hold(CPB);
    for (int k = 0; k < 32; k++) begin
      rx = w[k];
      hold(CPB);
    end
    rx = good;
    hold(CPB);
    rx = 1'b1;
    $display("frame sent: word=%h stop_ok=%0d start_cycle=%0d", w, good, last_start);
  endtask

  // Random consumer.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
    end
  end

  // The model is updated at each posedge and compared with the DUT at the following negedge.
  initial begin
    frame_t f;
    bit     old_valid;
    forever begin
      @(posedge clk);
      cyc++;
      if (reset === 1'b0) begin
        armed     = 1'b1;
        exp_valid = 1'b0;
        exp_ferr  = 1'b0;
        exp_ovr   = 1'b0;
        exp_data  = '0;
        pend_q.delete();
      end else if (armed) begin
        old_valid = exp_valid;
        exp_ferr  = 1'b0;
        if (exp_valid && rd_ready) begin
          exp_valid = 1'b0;
          exp_ovr   = 1'b0;
        end
        if (pend_q.size() > 0 && pend_q[0].done <= cyc) begin
          f = pend_q.pop_front();
          if (f.good) begin
            if (!old_valid || rd_ready) begin
              exp_data  = f.word;
              exp_valid = 1'b1;
            end else begin
              exp_ovr = 1'b1;
            end
          end else begin
            exp_ferr = 1'b1;
          end
        end
      end
      @(negedge clk);
      if (armed) begin
        check("data_valid", {31'd0, data_valid}, {31'd0, exp_valid});
        check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
        check("overrun", {31'd0, overrun}, {31'd0, exp_ovr});
        check("data", data, exp_data);
        if (data_valid && rd_ready) begin
          acc_q.push_back(data);
          $display("word accepted: data=%h cycle=%0d", data, cyc);
        end
        if (data_valid && !prev_valid) begin
          last_rise = cyc;
          rise_cnt++;
        end
        if (frame_err) ferr_cnt++;
        prev_valid = data_valid;
      end
    end
  end

  initial begin
    int          rc;
    int          fc;
    int          n0;
    logic [31:0] w;
    bit          good;

    rx       = 1'b1;
    reset    = 1'b0;
    rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rst_data", data, 32'h0);
    check("rst_valid", {31'd0, data_valid}, 32'h0);
    check("rst_ferr", {31'd0, frame_err}, 32'h0);
    check("rst_ovr", {31'd0, overrun}, 32'h0);
    check("rst_busy", {31'd0, busy}, 32'h0);
    @(posedge clk);
    #1;
    hold(5);

    // 1: single frame with latency pinned.
    rd_ready = 1'b1;
    rc = rise_cnt;
    send_frame(32'hA5A5_0F3C, 1'b1);
    hold(4);
    check("t1_latency", last_rise - last_start, 32'(LAT));
    check("t1_rises", 32'(rise_cnt - rc), 32'd1);
    check("t1_word", acc_q[$], 32'hA5A5_0F3C);
    busy_cycle(1'b0, "t1_busy_idle");

    // 2: 5-cycle glitch.
    rc = rise_cnt;
    rx = 1'b0;
    hold(5);
    rx = 1'b1;
    hold(4);
    busy_cycle(1'b1, "t2_busy_start");
    hold(10);
    busy_cycle(1'b0, "t2_busy_back");
    check("t2_no_word", 32'(rise_cnt - rc), 32'd0);
    send_frame(32'h0000_0001, 1'b1);
    hold(4);
    check("t2_word", acc_q[$], 32'h0000_0001);

    // 3: framing error followed by a break.
    rc = rise_cnt;
    fc = ferr_cnt;
    send_frame(32'hFFFF_FFFF, 1'b0);
    rx = 1'b0;
    hold(39);
    busy_cycle(1'b1, "t3_wait_idle");
    check("t3_ferr_pulses", 32'(ferr_cnt - fc), 32'd1);
    check("t3_no_word", 32'(rise_cnt - rc), 32'd0);
    rx = 1'b1;
    hold(3);
    busy_cycle(1'b0, "t3_idle");
    send_frame(32'h1234_5678, 1'b1);
    hold(4);
    check("t3_word", acc_q[$], 32'h1234_5678);

    // 4: overrun.
    rd_ready = 1'b0;
    send_frame(32'h1111_1111, 1'b1);
    hold(2);
    send_frame(32'h2222_2222, 1'b1);
    hold(4);
    @(negedge clk);
    check("t4_data_kept", data, 32'h1111_1111);
    check("t4_valid", {31'd0, data_valid}, 32'd1);
    check("t4_ovr", {31'd0, overrun}, 32'd1);
    @(posedge clk);
    #1;
    rd_ready = 1'b1;
    hold(1);
    rd_ready = 1'b0;
    @(negedge clk);
    check("t4_valid_clr", {31'd0, data_valid}, 32'd0);
    check("t4_ovr_clr", {31'd0, overrun}, 32'd0);
    @(posedge clk);
    #1;

    // 5: back-to-back frames.
    rd_ready = 1'b1;
    n0 = acc_q.size();
    send_frame(32'hDEAD_BEEF, 1'b1);
    send_frame(32'hCAFE_F00D, 1'b1);
    hold(4);
    check("t5_count", 32'(acc_q.size() - n0), 32'd2);
    if (acc_q.size() >= n0 + 2) begin
      check("t5_first", acc_q[n0], 32'hDEAD_BEEF);
      check("t5_second", acc_q[n0+1], 32'hCAFE_F00D);
    end

    // 6: reset during bit 10. Bits 10..31 are ones, so the rest of the frame cannot start a new one.
    w  = 32'hFFFF_FC5A;
    rc = rise_cnt;
    fc = ferr_cnt;
    rx = 1'b0;
    hold(CPB);
    for (int k = 0; k < 10; k++) begin
      rx = w[k];
      hold(CPB);
    end
    rx = w[10];
    hold(7);
    busy_cycle(1'b1, "t6_busy_mid");
    reset = 1'b0;
    hold(1);
    reset = 1'b1;
    busy_cycle(1'b0, "t6_busy_rst");
    hold(6);
    for (int k = 11; k < 32; k++) begin
      rx = w[k];
      hold(CPB);
    end
    rx = 1'b1;
    hold(CPB);
    check("t6_no_word", 32'(rise_cnt - rc), 32'd0);
    check("t6_no_ferr", 32'(ferr_cnt - fc), 32'd0);
    send_frame(32'h5A5A_1234, 1'b1);
    hold(4);
    check("t6_word", acc_q[$], 32'h5A5A_1234);

    // Random frames, gaps, stop errors and consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      w    = $urandom;
      good = ($urandom_range(0, 9) != 0);
      send_frame(w, good);
      hold(good ? int'($urandom_range(0, 6)) : int'($urandom_range(2, 6)));
    end
    rand_ready = 1'b0;
    hold(1);
    rd_ready = 1'b1;
    hold(20);
    check("pending_drained", 32'(pend_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
